// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and default bit timing.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int CORE_CLK_HZ               = 48_000_000;
    localparam int UART_BAUD_DEFAULT         = 57_600;
    localparam int UART_CLKS_PER_BIT_DEFAULT = CORE_CLK_HZ / UART_BAUD_DEFAULT;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; RST_VAL sets the reset level
// so an idle line does not look like an edge coming out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with valid/ready byte output, framing-error and overrun pulses.
// Define UART_RX_MAJORITY_EN to take every bit sample as a 2-of-3 vote over three cycles.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int IW       = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

    logic rx_s;
    logic rx_q;
    logic samp;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q  <= 1'b1;
            rx_qq <= 1'b1;
        end else begin
            rx_q  <= rx_s;
            rx_qq <= rx_q;
        end
    end

    assign samp = maj3(rx_s, rx_q, rx_qq);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_q <= 1'b1;
        else        rx_q <= rx_s;
    end

    assign samp = rx_s;
`endif

    // The synchronizer comes out of reset at 1, so a line that is already low would look
    // like a falling edge; edge detection stays disarmed until a real high has been seen.
    logic [1:0] settle_q;
    logic       armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
        end else if (rx_s) begin
            armed_q <= 1'b1;
        end
    end

    uart_state_e               state_q;
    logic [CW-1:0]             cnt_q;
    logic [IW-1:0]             bit_idx_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic                      good_q;
    logic                      frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            good_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            good_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (armed_q && rx_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= samp ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shreg_q   <= {samp, shreg_q[UART_DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == IDX_LAST) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                        good_q      <= samp;
                        frame_err_q <= !samp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic                      m_valid_d, m_valid_q;
    logic [UART_DATA_BITS-1:0] m_data_d, m_data_q;
    logic                      overrun_d, overrun_q;

    // A reload in the same cycle as an accept wins over the clear.
    always_comb begin
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        overrun_d = 1'b0;
        if (good_q) begin
            if (!m_valid_q || m_ready) begin
                m_valid_d = 1'b1;
                m_data_d  = shreg_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer using a short bit period; bytes seen by the
// consumer are collected and compared against what the sender put on the wire.
module tb_uart_rx_deframer;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Consumer-side observer: every handshake delivers one byte.
    logic [7:0] got_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         stab_err = 0;
    int         rise_cyc = -1;
    logic       prev_v = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (m_valid && !prev_v) rise_cyc = cyc;
        if (prev_hold && rst_n && (!m_valid || m_data != prev_d)) stab_err++;
        prev_hold = m_valid && !m_ready;
        prev_v    = m_valid;
        prev_d    = m_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit rnd_ready = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    int fall_cyc = 0;

    task automatic send_bit(input logic v, input bit glitch);
        rx = v;
        if (glitch) begin
            tick(HALF);
            rx = ~v;
            tick(1);
            rx = v;
            tick(CPB - HALF - 1);
        end else begin
            tick(CPB);
        end
    endtask

    task automatic send_body(input logic [7:0] d, input logic stop, input bit glitch);
        fall_cyc = cyc;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(stop, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input bit glitch);
        send_body(d, stop, glitch);
        rx = 1'b1;
        tick(gap * CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_n;
        int         exp_ferr;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] exp_q[$];
    int         n0, f0, o0, exp_ferr, lat;

    initial begin
        tbl[0] = '{8'h00, 1'b1, 2, 1, 0};
        tbl[1] = '{8'hFF, 1'b1, 1, 1, 0};
        tbl[2] = '{8'hA5, 1'b1, 1, 1, 0};
        tbl[3] = '{8'h80, 1'b1, 1, 1, 0};
        tbl[4] = '{8'h01, 1'b1, 2, 1, 0};
        tbl[5] = '{8'h5A, 1'b0, 2, 0, 1};

        // Reset state
        tick(3);
        check("rst m_valid", m_valid, 0);
        check("rst m_data", m_data, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overrun", overrun, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;
        tick(5);
        check("post-rst busy", busy, 0);
        check("post-rst m_valid", m_valid, 0);

        // Table-driven frames with an always-ready consumer
        m_ready = 1'b1;
        foreach (tbl[i]) begin
            n0 = got_q.size();
            f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, 1'b0);
            check($sformatf("vec%0d count", i), got_q.size() - n0, tbl[i].exp_n);
            if (tbl[i].exp_n == 1 && got_q.size() > 0)
                check($sformatf("vec%0d data", i), got_q[$], tbl[i].data);
            check($sformatf("vec%0d frame_err", i), ferr_cnt - f0, tbl[i].exp_ferr);
            if (i == 0) begin
                lat = rise_cyc - fall_cyc;
                check("latency window", (lat >= LAT - 1 && lat <= LAT + 1), 1);
            end
        end
        check("table overrun", ovr_cnt, 0);

        // Full holding register: second byte dropped with an overrun pulse
        m_ready = 1'b0;
        n0 = got_q.size();
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        send_frame(8'hC3, 1'b1, 2, 1'b0);
        check("hold m_valid", m_valid, 1);
        check("hold m_data", m_data, 8'h3C);
        check("hold overrun", ovr_cnt - o0, 1);
        check("hold none taken", got_q.size() - n0, 0);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(1);
        check("accept drops m_valid", m_valid, 0);
        check("accept count", got_q.size() - n0, 1);
        if (got_q.size() > 0) check("accept data", got_q[$], 8'h3C);

        // Bad stop bit followed by a break, then a good frame
        m_ready = 1'b1;
        n0 = got_q.size();
        f0 = ferr_cnt;
        send_body(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        tick(20 * CPB);
        check("break busy", busy, 0);
        check("break no byte", got_q.size() - n0, 0);
        rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h12, 1'b1, 2, 1'b0);
        check("break frame_err", ferr_cnt - f0, 1);
        check("after break count", got_q.size() - n0, 1);
        if (got_q.size() > 0) check("after break data", got_q[$], 8'h12);

        // Short low pulse on the line is rejected
        n0 = got_q.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(4);
        check("glitch busy high", busy, 1);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch busy low", busy, 0);
        check("glitch no byte", got_q.size() - n0, 0);
        check("glitch no err", ferr_cnt - f0, 0);

`ifdef UART_RX_MAJORITY_EN
        n0 = got_q.size();
        send_frame(8'hA5, 1'b1, 2, 1'b1);
        check("majority count", got_q.size() - n0, 1);
        if (got_q.size() > 0) check("majority data", got_q[$], 8'hA5);
`endif

        // Reset during data bit 4, released with the line low
        n0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        tick(HALF);
        check("mid-data busy", busy, 1);
        rst_n = 1'b0;
        tick(2);
        check("mid-rst busy", busy, 0);
        rst_n = 1'b1;
        tick(3 * CPB);
        check("low-release busy", busy, 0);
        rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h81, 1'b1, 2, 1'b0);
        check("rst recover count", got_q.size() - n0, 1);
        if (got_q.size() > 0) check("rst recover data", got_q[$], 8'h81);
        check("rst recover err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // Random bytes, random stop bits and gaps, randomly stalling consumer
        n0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        exp_ferr = 0;
        rnd_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 5) != 0);
            if (s) exp_q.push_back(d);
            else   exp_ferr++;
            send_frame(d, s, $urandom_range(1, 3), 1'b0);
        end
        tick(4 * CPB);
        rnd_ready = 1'b0;
        m_ready = 1'b1;
        tick(2);
        check("rand count", got_q.size() - n0, exp_q.size());
        for (int k = 0; k < exp_q.size() && n0 + k < got_q.size(); k++)
            check($sformatf("rand byte%0d", k), got_q[n0 + k], exp_q[k]);
        check("rand frame_err", ferr_cnt - f0, exp_ferr);
        check("rand overrun", ovr_cnt - o0, 0);
        check("hold stable", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
